// File: rtl/sr_latch.sv
// sr_latch: clocked set/reset flag cell with complementary outputs,
// optional input synchronisers and reporting of the S=R=1 condition.
module sr_latch #(
  parameter int INVALID_POLICY = 0,  // 0 NOR emulation, 1 set, 2 reset, 3 hold
  parameter int SYNC_STAGES    = 0   // 0..3 register stages on S and R
) (
  input  logic clk,
  input  logic rst_n,
  input  logic S,
  input  logic R,
  input  logic clr_err,
  output logic Q,
  output logic Q_bar,
  output logic invalid,
  output logic invalid_sticky,
  output logic changed
);

  logic s_i;
  logic r_i;

  logic q_reg, q_next;
  logic qbar_reg, qbar_next;
  logic inv_reg, inv_next;
  logic sticky_reg, sticky_next;
  logic changed_reg, changed_next;
  logic q_prev_reg;

  // Input conditioning: either straight through or a chain of flops.
  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign s_i = S;
      assign r_i = R;
    end else begin : g_sync
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        logic s_stage_reg;
        logic r_stage_reg;
        logic s_prev;
        logic r_prev;
        if (gi == 0) begin : g_first
          assign s_prev = S;
          assign r_prev = R;
        end else begin : g_chain
          assign s_prev = g_stage[gi-1].s_stage_reg;
          assign r_prev = g_stage[gi-1].r_stage_reg;
        end
        // One synchroniser stage; reset clears any request in flight.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            s_stage_reg <= 1'b0;
            r_stage_reg <= 1'b0;
          end else begin
            s_stage_reg <= s_prev;
            r_stage_reg <= r_prev;
          end
        end
      end
      assign s_i = g_stage[SYNC_STAGES-1].s_stage_reg;
      assign r_i = g_stage[SYNC_STAGES-1].r_stage_reg;
    end
  endgenerate

  // Next-state decode of the stored bit, its complement and the flags.
  always_comb begin
    q_next       = q_reg;
    qbar_next    = qbar_reg;
    inv_next     = 1'b0;
    sticky_next  = sticky_reg;
    changed_next = (q_reg != q_prev_reg);

    unique case ({s_i, r_i})
      2'b00: begin
        // Both outputs low only after a NOR-style invalid; settle to reset.
        if (!q_reg && !qbar_reg) begin
          qbar_next = 1'b1;
        end
      end
      2'b10: begin
        q_next    = 1'b1;
        qbar_next = 1'b0;
      end
      2'b01: begin
        q_next    = 1'b0;
        qbar_next = 1'b1;
      end
      2'b11: begin
        inv_next = 1'b1;
        case (INVALID_POLICY)
          0: begin
            q_next    = 1'b0;
            qbar_next = 1'b0;
          end
          1: begin
            q_next    = 1'b1;
            qbar_next = 1'b0;
          end
          2: begin
            q_next    = 1'b0;
            qbar_next = 1'b1;
          end
          default: begin
            q_next    = q_reg;
            qbar_next = qbar_reg;
          end
        endcase
      end
      default: ;
    endcase

    // An invalid edge wins over a simultaneous clear request.
    if (s_i && r_i) begin
      sticky_next = 1'b1;
    end else if (clr_err) begin
      sticky_next = 1'b0;
    end
  end

  // State register; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg       <= 1'b0;
      qbar_reg    <= 1'b1;
      inv_reg     <= 1'b0;
      sticky_reg  <= 1'b0;
      changed_reg <= 1'b0;
      q_prev_reg  <= 1'b0;
    end else begin
      q_reg       <= q_next;
      qbar_reg    <= qbar_next;
      inv_reg     <= inv_next;
      sticky_reg  <= sticky_next;
      changed_reg <= changed_next;
      q_prev_reg  <= q_reg;
    end
  end

  assign Q              = q_reg;
  assign Q_bar          = qbar_reg;
  assign invalid        = inv_reg;
  assign invalid_sticky = sticky_reg;
  assign changed        = changed_reg;

endmodule

// File: tb/tb_sr_latch.sv
// tb_sr_latch: drives five sr_latch variants (policies 0..3 without
// synchronisers, policy 0 with two stages) from shared stimulus and checks
// every output against a rule-level model each cycle.
module tb_sr_latch;

  localparam int NI   = 5;
  localparam int MAXE = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic S = 1'b0;
  logic R = 1'b0;
  logic clr_err = 1'b0;

  logic q_w   [NI];
  logic qb_w  [NI];
  logic inv_w [NI];
  logic st_w  [NI];
  logic ch_w  [NI];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      sr_latch #(
        .INVALID_POLICY((gi < 4) ? gi : 0),
        .SYNC_STAGES   ((gi == 4) ? 2 : 0)
      ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .S             (S),
        .R             (R),
        .clr_err       (clr_err),
        .Q             (q_w[gi]),
        .Q_bar         (qb_w[gi]),
        .invalid       (inv_w[gi]),
        .invalid_sticky(st_w[gi]),
        .changed       (ch_w[gi])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_errors = 0;

  // Input history per clock edge, used to derive what each variant's logic sees.
  bit s_h   [MAXE];
  bit r_h   [MAXE];
  bit rst_h [MAXE];
  int edge_k = 0;

  // Model state per variant.
  int pol [NI];
  int stg [NI];
  bit m_q [NI];
  bit m_qb[NI];
  bit m_inv[NI];
  bit m_st[NI];
  bit m_ch[NI];
  bit m_qp[NI];

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b expected=%b", tag, obs, exp);
    end
  endtask

  // A request reaches the latch logic 'n' edges late, and only if no reset
  // edge occurred while it was travelling through the stages.
  function automatic bit delayed(input bit is_s, input int n);
    if (n == 0) return is_s ? s_h[edge_k] : r_h[edge_k];
    if (edge_k - n < 0) return 1'b0;
    for (int j = edge_k - n; j < edge_k; j++)
      if (!rst_h[j]) return 1'b0;
    return is_s ? s_h[edge_k - n] : r_h[edge_k - n];
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      bit si, ri;
      si = delayed(1'b1, stg[i]);
      ri = delayed(1'b0, stg[i]);
      if (!rst_h[edge_k]) begin
        m_q[i] = 0; m_qb[i] = 1; m_inv[i] = 0; m_st[i] = 0; m_ch[i] = 0; m_qp[i] = 0;
      end else begin
        // changed reports a Q transition made on the previous edge
        m_ch[i] = (m_q[i] != m_qp[i]);
        m_qp[i] = m_q[i];
        m_inv[i] = si && ri;
        if (si && ri) begin
          m_st[i] = 1;
          if (pol[i] == 0)      begin m_q[i] = 0; m_qb[i] = 0; end
          else if (pol[i] == 1) begin m_q[i] = 1; m_qb[i] = 0; end
          else if (pol[i] == 2) begin m_q[i] = 0; m_qb[i] = 1; end
        end else begin
          if (clr_err) m_st[i] = 0;
          if (si)      begin m_q[i] = 1; m_qb[i] = 0; end
          else if (ri) begin m_q[i] = 0; m_qb[i] = 1; end
          else         m_qb[i] = ~m_q[i];
        end
      end
    end
  endtask

  task automatic step(input bit s, input bit r, input bit clr, input bit rst);
    S = s; R = r; clr_err = clr; rst_n = rst;
    @(posedge clk);
    s_h[edge_k] = s; r_h[edge_k] = r; rst_h[edge_k] = rst;
    model_edge();
    #1;
    for (int i = 0; i < NI; i++) begin
      check_bit($sformatf("e%0d u%0d Q", edge_k, i), q_w[i], m_q[i]);
      check_bit($sformatf("e%0d u%0d Q_bar", edge_k, i), qb_w[i], m_qb[i]);
      check_bit($sformatf("e%0d u%0d invalid", edge_k, i), inv_w[i], m_inv[i]);
      check_bit($sformatf("e%0d u%0d sticky", edge_k, i), st_w[i], m_st[i]);
      check_bit($sformatf("e%0d u%0d changed", edge_k, i), ch_w[i], m_ch[i]);
    end
    $display("edge %0d rst_n=%b S=%b R=%b clr=%b | Q=%b%b%b%b%b Qb=%b%b%b%b%b inv=%b st=%b ch=%b",
             edge_k, rst, s, r, clr, q_w[0], q_w[1], q_w[2], q_w[3], q_w[4],
             qb_w[0], qb_w[1], qb_w[2], qb_w[3], qb_w[4], inv_w[0], st_w[0], ch_w[0]);
    edge_k++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      pol[i] = (i < 4) ? i : 0;
      stg[i] = (i == 4) ? 2 : 0;
      m_q[i] = 0; m_qb[i] = 1; m_inv[i] = 0; m_st[i] = 0; m_ch[i] = 0; m_qp[i] = 0;
    end

    // Power-up reset then idle.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_bit("reset Q", q_w[0], 1'b0);
    check_bit("reset Q_bar", qb_w[0], 1'b1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

    // Set, hold, reset, hold.
    step(1, 0, 0, 1);
    check_bit("set Q", q_w[0], 1'b1);
    step(0, 0, 0, 1);
    check_bit("set changed pulse", ch_w[0], 1'b1);
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    check_bit("reset Q_bar", qb_w[0], 1'b1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Invalid from Q=0, then release, then set and reset.
    step(1, 1, 0, 1);
    check_bit("nor invalid Q_bar", qb_w[0], 1'b0);
    step(0, 0, 0, 1);
    check_bit("nor exit Q_bar", qb_w[0], 1'b1);
    step(1, 0, 0, 1);
    step(0, 1, 0, 1);

    // Invalid from Q=1 for the other policies.
    step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    check_bit("hold policy Q", q_w[3], 1'b1);
    step(0, 0, 0, 1);

    // Sticky clear, then clear colliding with an invalid edge.
    step(0, 0, 1, 1);
    check_bit("sticky cleared", st_w[0], 1'b0);
    step(1, 1, 1, 1);
    check_bit("sticky set wins", st_w[0], 1'b1);
    step(0, 1, 1, 1);
    step(0, 0, 0, 1);

    // Single-cycle S pulse through the two-stage variant, then reset while set.
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    check_bit("sync2 not yet", q_w[4], 1'b0);
    step(0, 0, 0, 1);
    check_bit("sync2 set at 3rd edge", q_w[4], 1'b1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    check_bit("mid reset Q", q_w[4], 1'b0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);

    // Randomised traffic with occasional clears and resets.
    for (int n = 0; n < 400; n++) begin
      bit s, r, c, rs;
      s  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 2) == 0);
      c  = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 39) != 0);
      step(s, r, c, rs);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_latch.md
Name: sr_latch

Overview:
- Clocked set/reset storage element: a single bit is set by S, cleared by R and held when both are low.
- Complementary outputs Q/Q_bar plus status flags for the illegal S=R=1 condition.
- Used as a generic control/status flag cell; software-visible error state is reported through the sticky flag.
- All state is updated on the rising edge of clk; there is no asynchronous path from S/R to Q.

Parameters:
- INVALID_POLICY, 0, action on S=R=1. 0 = NOR-latch emulation (Q=0, Q_bar=0 while asserted); 1 = set-dominant; 2 = reset-dominant; 3 = hold.
- SYNC_STAGES, 0, number of flip-flop stages on S and R before the latch logic. Legal range 0..3; 0 means S/R are used directly.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- S, input, 1, set request (level).
- R, input, 1, reset request (level).
- clr_err, input, 1, clears invalid_sticky (level, sampled on clk).
- Q, output, 1, stored state.
- Q_bar, output, 1, complement output; see invalid rules.
- invalid, output, 1, high for each cycle the latch logic sees S=R=1.
- invalid_sticky, output, 1, latched record of any invalid condition.
- changed, output, 1, one-cycle pulse when Q changed on the previous edge.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, Q=0, Q_bar=1, invalid=0, invalid_sticky=0, changed=0, and all sync stages are cleared to 0. Reset dominates S, R and clr_err.
- Let s_i/r_i be S/R after SYNC_STAGES registers; with 0 stages they are S/R directly.
- Latency: Q reflects an S/R level one clk edge after s_i/r_i present it, i.e. 1+SYNC_STAGES edges after the S/R inputs.
- Each edge, with rst_n=1:
  - s_i=0, r_i=0: hold; Q and Q_bar keep their values.
  - s_i=1, r_i=0: Q=1, Q_bar=0.
  - s_i=0, r_i=1: Q=0, Q_bar=1.
  - s_i=1, r_i=1: invalid=1 and invalid_sticky=1, with outputs set by policy:
    - Policy 0: Q=0, Q_bar=0.
    - Policy 1: Q=1, Q_bar=0.
    - Policy 2: Q=0, Q_bar=1.
    - Policy 3: hold.
- invalid is a register: 1 exactly for edges where s_i=r_i=1, otherwise 0.
- Exit from invalid under policy 0 is deterministic, with no race. When s_i=r_i=0 follows S=R=1, the internal state resolves to reset: Q=0, Q_bar=1.
- Outside policy-0 invalid cycles, Q_bar == ~Q at all times.
- invalid_sticky:
  - Set by any invalid edge.
  - Cleared by clr_err=1 on an edge without a simultaneous invalid.
  - Set wins when clr_err=1 and s_i=r_i=1 on the same edge.
- changed: registered, 1 on the edge after Q differs from its prior value; otherwise 0.
- Re-asserting S when already set: Q stays 1 and changed=0. Same applies to R when already reset.
- Reset mid-operation (e.g. while S=1): outputs go to reset values on that edge. Q then goes to 1 one edge after rst_n returns high, if S is still 1.
- No combinational path from inputs to outputs.

Test Plan:
- Power-up, rst_n=0 for 2 edges, S=R=0 → Q=0, Q_bar=1, all flags 0. Release rst_n and hold S=R=0 for 10 cycles → unchanged.
- Policy 0, SYNC_STAGES=0, set/reset/hold:
  - S=1,R=0 → next edge Q=1, Q_bar=0, then changed=1 for one cycle.
  - S=R=0 → Q stays 1.
  - S=0,R=1 → Q=0, Q_bar=1.
  - S=R=0 → holds 0.
- Invalid, policy 0: from Q=0, apply S=R=1 → Q=0, Q_bar=0, invalid=1, invalid_sticky=1. Then S=R=0 → Q=0, Q_bar=1, invalid=0, invalid_sticky stays 1. Then S=1 → Q=1. Then R=1 → Q=0.
- Policies 1/2/3: apply S=R=1 from Q=0 and from Q=1.
  - Policy 1 → Q=1, Q_bar=0.
  - Policy 2 → Q=0, Q_bar=1.
  - Policy 3 → Q unchanged, Q_bar=~Q.
  - invalid=1 in all cases.
- Sticky clear: after invalid, clr_err=1 for one edge with S=R=0 → invalid_sticky=0. Then clr_err=1 with S=R=1 on the same edge → invalid_sticky=1.
- SYNC_STAGES=2: pulse S=1 for one cycle → Q=1 exactly 3 edges later. Assert rst_n=0 while Q=1 → Q=0, Q_bar=1 on that edge.
